// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter.
// Edge- or center-aligned counting is selectable at run time, and each
// channel's duty is double-buffered. New duties and a new mode take effect
// only at a period boundary, so every period completes without glitches.
// The counter advances only on cycles where ena and step are both high.
module pwm_multi #(
  parameter int N        = 8,
  parameter int CHANNELS = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                step,
  input  logic                mode,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_chan,
  input  logic [N-1:0]        wr_duty,
  output logic [CHANNELS-1:0] out,
  output logic                period_start
);

  localparam logic [N-1:0] ONE_CNT  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MAX_CNT  = {N{1'b1}};
  localparam logic [N-1:0] TOP_CNT  = MAX_CNT - ONE_CNT;
  localparam logic [CW:0]  CHAN_LIM = (CW+1)'(CHANNELS);

  logic [N-1:0]        cnt_r;
  logic                dir_r;          // 0 = counting up, 1 = counting down
  logic                mode_act_r;     // mode applied to the running period
  logic                ena_q_r;        // ena from the previous cycle, for rise detection
  logic [N-1:0]        pending_r [CHANNELS];
  logic [N-1:0]        active_r  [CHANNELS];
  logic [CHANNELS-1:0] out_r;
  logic                period_start_r;

  logic                wr_hit_s;
  logic                advance_s;
  logic                boundary_s;
  logic [N-1:0]        pending_nxt_s [CHANNELS];
  logic [CHANNELS-1:0] out_nxt_s;

  // Decode the write, the advance and the period boundary (the advance that returns cnt to 0).
  always_comb begin
    wr_hit_s   = wr_en & ({1'b0, wr_chan} < CHAN_LIM);
    advance_s  = ena & step;
    boundary_s = advance_s & (mode_act_r ? (dir_r & (cnt_r == ONE_CNT))
                                         : (cnt_r == TOP_CNT));
  end

  // Next pending duties, with the same-cycle write folded in so a boundary load sees it.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      pending_nxt_s[i] = (wr_hit_s && (wr_chan == CW'(i))) ? wr_duty : pending_r[i];
    end
  end

  // Compare the current count against each active duty.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      out_nxt_s[i] = ena & (cnt_r < active_r[i]);
    end
  end

  // Shared period counter, count direction and latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {N{1'b0}};
      dir_r      <= 1'b0;
      mode_act_r <= 1'b0;
    end else if (!ena) begin
      cnt_r      <= {N{1'b0}};
      dir_r      <= 1'b0;
      mode_act_r <= mode;
    end else if (boundary_s) begin
      cnt_r      <= {N{1'b0}};
      dir_r      <= 1'b0;
      mode_act_r <= mode;
    end else if (advance_s) begin
      if (mode_act_r && !dir_r && (cnt_r == TOP_CNT)) begin
        // Turn around at the top: the peak value is shown only once.
        cnt_r <= cnt_r - ONE_CNT;
        dir_r <= 1'b1;
      end else if (dir_r) begin
        cnt_r <= cnt_r - ONE_CNT;
        dir_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + ONE_CNT;
        dir_r <= 1'b0;
      end
    end else begin
      cnt_r      <= cnt_r;
      dir_r      <= dir_r;
      mode_act_r <= mode_act_r;
    end
  end

  // Double-buffered duties: writes land in pending; active copies pending at boundaries or while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending_r[i] <= {N{1'b0}};
        active_r[i]  <= {N{1'b0}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pending_r[i] <= pending_nxt_s[i];
        if (!ena || boundary_s) begin
          active_r[i] <= pending_nxt_s[i];
        end else begin
          active_r[i] <= active_r[i];
        end
      end
    end
  end

  // Registered PWM outputs, plus the period-start pulse on a boundary or on the rise of ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r          <= {CHANNELS{1'b0}};
      period_start_r <= 1'b0;
      ena_q_r        <= 1'b0;
    end else begin
      out_r          <= out_nxt_s;
      period_start_r <= ena & (boundary_s | ~ena_q_r);
      ena_q_r        <= ena;
    end
  end

  assign out          = out_r;
  assign period_start = period_start_r;

endmodule
